// File: rtl/parse_arbiter_pkg.sv
// Shared widths, requester ids and range helper for the fetch/load parse path.
// Latency: none (definitions only).
// Backpressure: n/a.
package parse_arbiter_pkg;

   localparam int OFFSET_SIZE  = 5;
   localparam int INDEX_SIZE   = 8;
   localparam int TAG_SIZE     = 64 - (OFFSET_SIZE + INDEX_SIZE);
   localparam int LINE_BITS    = (2**OFFSET_SIZE) * 8;
   localparam int PAYLOAD_BITS = 32;
   localparam int FIFO_DEPTH   = 2;

   // Requester identities, shared by the fetch and load units.
   typedef enum logic {
      FETCH = 1'b0,
      LOAD  = 1'b1
   } req_id_e;

   // An extraction window that runs past the end of the line cannot be parsed.
   function automatic logic out_of_range(input int offset, input int payload_bits,
                                         input int line_bits);
      return (offset * 8 + payload_bits) > line_bits;
   endfunction

endpackage

// File: rtl/parse_req_fifo.sv
// Per-requester request queue: circular buffer with registered occupancy.
// Latency: an entry is visible at data_o the cycle after it is pushed (no bypass).
// Backpressure: full_o from registered occupancy; pushes while full or during flush are dropped.
module parse_req_fifo
   import parse_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   // Next pointer/occupancy; pointers wrap explicitly at DEPTH-1.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Pointer and occupancy state; reset empties the queue.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clock_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/parse_arbiter.sv
// Round-robin arbiter feeding fetch/load requests to a 1-cycle line parser.
// Latency: enqueue->grant >= 1 cycle, grant->response exactly 1 cycle.
// Backpressure: reqReadyN_o = queue not full (low in reset); responses cannot be stalled.
module parse_arbiter
   import parse_arbiter_pkg::*;
#(
   parameter int offsetSize           = OFFSET_SIZE,
   parameter int indexSize            = INDEX_SIZE,
   parameter int tagSize              = 64 - (offsetSize + indexSize),
   parameter int cachelineSizeInBits  = (2**offsetSize) * 8,
   parameter int parsePayloadSizeBits = PAYLOAD_BITS,
   parameter int fifoDepth            = FIFO_DEPTH
) (
   input  logic                            clock_i,
   input  logic                            reset_i,
   input  logic                            flush_i,
   // fetch requester
   input  logic                            reqValid0_i,
   output logic                            reqReady0_o,
   input  logic [cachelineSizeInBits-1:0]  reqCacheline0_i,
   input  logic [tagSize-1:0]              reqTag0_i,
   input  logic [indexSize-1:0]            reqIndex0_i,
   input  logic [offsetSize-1:0]           reqOffset0_i,
   // load requester
   input  logic                            reqValid1_i,
   output logic                            reqReady1_o,
   input  logic [cachelineSizeInBits-1:0]  reqCacheline1_i,
   input  logic [tagSize-1:0]              reqTag1_i,
   input  logic [indexSize-1:0]            reqIndex1_i,
   input  logic [offsetSize-1:0]           reqOffset1_i,
   // parser request side
   output logic                            parseEnable_o,
   output logic [cachelineSizeInBits-1:0]  parseCacheline_o,
   output logic [tagSize-1:0]              parseTag_o,
   output logic [indexSize-1:0]            parseIndex_o,
   output logic [offsetSize-1:0]           parseOffset_o,
   // parser result side
   input  logic                            parseEnable_i,
   input  logic [parsePayloadSizeBits-1:0] parsePayload_i,
   input  logic [tagSize-1:0]              parseTag_i,
   input  logic [indexSize-1:0]            parseIndex_i,
   input  logic [offsetSize-1:0]           parseOffset_i,
   // fetch response
   output logic                            respValid0_o,
   output logic                            respErr0_o,
   output logic [parsePayloadSizeBits-1:0] respPayload0_o,
   output logic [tagSize-1:0]              respTag0_o,
   output logic [indexSize-1:0]            respIndex0_o,
   output logic [offsetSize-1:0]           respOffset0_o,
   // load response
   output logic                            respValid1_o,
   output logic                            respErr1_o,
   output logic [parsePayloadSizeBits-1:0] respPayload1_o,
   output logic [tagSize-1:0]              respTag1_o,
   output logic [indexSize-1:0]            respIndex1_o,
   output logic [offsetSize-1:0]           respOffset1_o
);

   localparam int ENTRY_W = cachelineSizeInBits + tagSize + indexSize + offsetSize;

   logic [1:0]               fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [ENTRY_W-1:0]       fifo_head0, fifo_head1, head_dat;
   logic [cachelineSizeInBits-1:0] head_line;
   logic [tagSize-1:0]       head_tag;
   logic [indexSize-1:0]     head_index;
   logic [offsetSize-1:0]    head_offset;
   logic                     head_err;

   logic                     grant_vld;
   req_id_e                  grant_id;
   req_id_e                  last_grant_q, last_grant_d;

   logic                     pipe_vld_q, pipe_vld_d;
   req_id_e                  pipe_id_q, pipe_id_d;
   logic                     pipe_err_q, pipe_err_d;
   logic [tagSize-1:0]       pipe_tag_q, pipe_tag_d;
   logic [indexSize-1:0]     pipe_index_q, pipe_index_d;
   logic [offsetSize-1:0]    pipe_offset_q, pipe_offset_d;

   logic                     resp_vld, resp_ok;
   logic [parsePayloadSizeBits-1:0] resp_payload;
   logic [tagSize-1:0]       resp_tag;
   logic [indexSize-1:0]     resp_index;
   logic [offsetSize-1:0]    resp_offset;

   // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
   assign reqReady0_o  = ~fifo_full[0] & ~reset_i;
   assign reqReady1_o  = ~fifo_full[1] & ~reset_i;
   assign fifo_push[0] = reqValid0_i & reqReady0_o & ~flush_i;
   assign fifo_push[1] = reqValid1_i & reqReady1_o & ~flush_i;

   parse_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(fifoDepth)) u_fetch_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (fifo_push[0]),
      .data_i  ({reqCacheline0_i, reqTag0_i, reqIndex0_i, reqOffset0_i}),
      .pop_i   (fifo_pop[0]),
      .data_o  (fifo_head0),
      .full_o  (fifo_full[0]),
      .empty_o (fifo_empty[0])
   );

   parse_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(fifoDepth)) u_load_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (fifo_push[1]),
      .data_i  ({reqCacheline1_i, reqTag1_i, reqIndex1_i, reqOffset1_i}),
      .pop_i   (fifo_pop[1]),
      .data_o  (fifo_head1),
      .full_o  (fifo_full[1]),
      .empty_o (fifo_empty[1])
   );

   // Round-robin pick among non-empty queues; reset and flush suppress any grant.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = FETCH;
      if (!reset_i && !flush_i) begin
         if (!fifo_empty[0] && !fifo_empty[1]) begin
            grant_vld = 1'b1;
            grant_id  = (last_grant_q == FETCH) ? LOAD : FETCH;
         end else if (!fifo_empty[0]) begin
            grant_vld = 1'b1;
            grant_id  = FETCH;
         end else if (!fifo_empty[1]) begin
            grant_vld = 1'b1;
            grant_id  = LOAD;
         end
      end
   end

   assign fifo_pop[0] = grant_vld & (grant_id == FETCH);
   assign fifo_pop[1] = grant_vld & (grant_id == LOAD);

   assign head_dat = (grant_id == LOAD) ? fifo_head1 : fifo_head0;
   assign {head_line, head_tag, head_index, head_offset} = head_dat;
   assign head_err = out_of_range(int'(head_offset), parsePayloadSizeBits, cachelineSizeInBits);

   // Out-of-range entries are still popped, but never reach the parser.
   assign parseEnable_o    = grant_vld & ~head_err;
   assign parseCacheline_o = head_line;
   assign parseTag_o       = head_tag;
   assign parseIndex_o     = head_index;
   assign parseOffset_o    = head_offset;

   // Next state for the arbitration history and the grant shadow pipeline.
   always_comb begin
      last_grant_d  = grant_vld ? grant_id : last_grant_q;
      pipe_vld_d    = grant_vld;
      pipe_id_d     = pipe_id_q;
      pipe_err_d    = pipe_err_q;
      pipe_tag_d    = pipe_tag_q;
      pipe_index_d  = pipe_index_q;
      pipe_offset_d = pipe_offset_q;
      if (grant_vld) begin
         pipe_id_d     = grant_id;
         pipe_err_d    = head_err;
         pipe_tag_d    = head_tag;
         pipe_index_d  = head_index;
         pipe_offset_d = head_offset;
      end
   end

   // lastGrant resets to LOAD so fetch wins the first contention.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         last_grant_q <= LOAD;
         pipe_vld_q   <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         pipe_vld_q   <= pipe_vld_d;
      end
      pipe_id_q     <= pipe_id_d;
      pipe_err_q    <= pipe_err_d;
      pipe_tag_q    <= pipe_tag_d;
      pipe_index_q  <= pipe_index_d;
      pipe_offset_q <= pipe_offset_d;
   end

   // Steer the in-flight result to its requester; reset and flush kill it outright.
   always_comb begin
      resp_vld     = pipe_vld_q & ~reset_i & ~flush_i;
      resp_ok      = resp_vld & ~pipe_err_q;
      resp_payload = (resp_ok & parseEnable_i) ? parsePayload_i : '0;
      resp_tag     = pipe_err_q ? pipe_tag_q    : parseTag_i;
      resp_index   = pipe_err_q ? pipe_index_q  : parseIndex_i;
      resp_offset  = pipe_err_q ? pipe_offset_q : parseOffset_i;
   end

   assign respValid0_o   = resp_vld & (pipe_id_q == FETCH);
   assign respValid1_o   = resp_vld & (pipe_id_q == LOAD);
   assign respErr0_o     = respValid0_o & pipe_err_q;
   assign respErr1_o     = respValid1_o & pipe_err_q;
   assign respPayload0_o = (pipe_id_q == FETCH) ? resp_payload : '0;
   assign respPayload1_o = (pipe_id_q == LOAD)  ? resp_payload : '0;
   assign respTag0_o     = resp_tag;
   assign respTag1_o     = resp_tag;
   assign respIndex0_o   = resp_index;
   assign respIndex1_o   = resp_index;
   assign respOffset0_o  = resp_offset;
   assign respOffset1_o  = resp_offset;

endmodule

// File: tb/tb_parse_arbiter.sv
// Self-checking bench for parse_arbiter with a 1-cycle mock parser and a queue-based model.
// Latency: model predicts every output of every cycle.
// Backpressure: requesters honour ready; responses are consumed immediately.
`timescale 1ns/1ps
module tb_parse_arbiter;
   import parse_arbiter_pkg::*;

   localparam int OW = OFFSET_SIZE;
   localparam int IW = INDEX_SIZE;
   localparam int TW = TAG_SIZE;
   localparam int LW = LINE_BITS;
   localparam int PW = PAYLOAD_BITS;
   localparam int D  = FIFO_DEPTH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, v0, v1;
   logic r0, r1;
   logic [LW-1:0] line0, line1, p_line_o;
   logic [TW-1:0] tag0, tag1, p_tag_o, rt0, rt1;
   logic [IW-1:0] idx0, idx1, p_idx_o, ri0, ri1;
   logic [OW-1:0] off0, off1, p_off_o, ro0, ro1;
   logic          pen_o, rv0, rv1, re0, re1;
   logic [PW-1:0] rp0, rp1;
   // mock parser result registers
   logic          pen_i = 1'b0;
   logic [PW-1:0] pay_i = '0;
   logic [TW-1:0] ptag_i = '0;
   logic [IW-1:0] pidx_i = '0;
   logic [OW-1:0] poff_i = '0;

   parse_arbiter dut (
      .clock_i(clk), .reset_i(rst), .flush_i(flush),
      .reqValid0_i(v0), .reqReady0_o(r0), .reqCacheline0_i(line0), .reqTag0_i(tag0),
      .reqIndex0_i(idx0), .reqOffset0_i(off0),
      .reqValid1_i(v1), .reqReady1_o(r1), .reqCacheline1_i(line1), .reqTag1_i(tag1),
      .reqIndex1_i(idx1), .reqOffset1_i(off1),
      .parseEnable_o(pen_o), .parseCacheline_o(p_line_o), .parseTag_o(p_tag_o),
      .parseIndex_o(p_idx_o), .parseOffset_o(p_off_o),
      .parseEnable_i(pen_i), .parsePayload_i(pay_i), .parseTag_i(ptag_i),
      .parseIndex_i(pidx_i), .parseOffset_i(poff_i),
      .respValid0_o(rv0), .respErr0_o(re0), .respPayload0_o(rp0), .respTag0_o(rt0),
      .respIndex0_o(ri0), .respOffset0_o(ro0),
      .respValid1_o(rv1), .respErr1_o(re1), .respPayload1_o(rp1), .respTag1_o(rt1),
      .respIndex1_o(ri1), .respOffset1_o(ro1)
   );

   // Big-endian byte extraction: byte i of the line lives at bits [i*8 +: 8].
   function automatic logic [PW-1:0] extract(input logic [LW-1:0] l, input int off);
      logic [PW-1:0] v;
      v = '0;
      for (int k = 0; k < PW / 8; k++)
         if (off + k < LW / 8) v = {v[PW-9:0], l[(off+k)*8 +: 8]};
      return v;
   endfunction

   function automatic bit oor(input int off);
      return (off * 8 + PW) > LW;
   endfunction

   // Mock parser: fixed 1-cycle latency, echoes the request fields.
   always @(posedge clk) begin
      pen_i  <= pen_o;
      pay_i  <= pen_o ? extract(p_line_o, int'(p_off_o)) : '0;
      ptag_i <= p_tag_o;
      pidx_i <= p_idx_o;
      poff_i <= p_off_o;
   end

   typedef struct {
      logic [LW-1:0] line;
      logic [TW-1:0] tag;
      logic [IW-1:0] idx;
      logic [OW-1:0] off;
   } req_t;

   typedef struct {
      bit            id;
      bit            err;
      logic [PW-1:0] pay;
      int            cyc;
   } rsp_t;

   typedef struct {
      bit            id;
      int            off;
      bit            err;
      logic [PW-1:0] pay;
   } vec_t;

   req_t mq0[$], mq1[$];
   bit   m_last = 1'b1, m_pv = 1'b0, m_pid = 1'b0, m_perr = 1'b0, post_rst = 1'b0;
   logic [PW-1:0] m_ppay = '0;
   req_t m_preq;
   rsp_t rlog[$];
   int   plog[$];
   int   n_chk = 0, n_pass = 0, cyc = 0, n_both = 0;
   bit   obs_r0, obs_r1, obs_rv0, obs_rv1, obs_pen;
   logic [TW-1:0] obs_ptag;
   logic [LW-1:0] lineb;
   vec_t vt[6];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One clock: compare every output against the model, then advance the model at the edge.
   task automatic step();
      bit g, gid, herr, rd0, rd1, ev0, ev1;
      req_t h, r;
      #1;
      cyc++;
      rd0 = !rst && (mq0.size() < D);
      rd1 = !rst && (mq1.size() < D);
      chk("ready0", r0, rd0);
      chk("ready1", r1, rd1);
      g = 0; gid = 0; herr = 0;
      h = '{default: '0};
      if (!rst && !flush) begin
         if (mq0.size() > 0 && mq1.size() > 0) begin g = 1; gid = !m_last; end
         else if (mq0.size() > 0) begin g = 1; gid = 0; end
         else if (mq1.size() > 0) begin g = 1; gid = 1; end
      end
      if (g) begin
         h = gid ? mq1[0] : mq0[0];
         herr = oor(int'(h.off));
      end
      chk("parse_en", pen_o, g && !herr);
      if (g && !herr) begin
         chk("parse_line", p_line_o, h.line);
         chk("parse_tag", p_tag_o, h.tag);
         chk("parse_idx", p_idx_o, h.idx);
         chk("parse_off", p_off_o, h.off);
      end
      ev0 = !rst && !flush && m_pv && !m_pid;
      ev1 = !rst && !flush && m_pv && m_pid;
      chk("resp_vld0", rv0, ev0);
      chk("resp_vld1", rv1, ev1);
      if (ev0) begin
         chk("resp_err0", re0, m_perr);   chk("resp_pay0", rp0, m_ppay);
         chk("resp_tag0", rt0, m_preq.tag); chk("resp_idx0", ri0, m_preq.idx);
         chk("resp_off0", ro0, m_preq.off);
      end
      if (ev1) begin
         chk("resp_err1", re1, m_perr);   chk("resp_pay1", rp1, m_ppay);
         chk("resp_tag1", rt1, m_preq.tag); chk("resp_idx1", ri1, m_preq.idx);
         chk("resp_off1", ro1, m_preq.off);
      end
      if (rst || post_rst) begin
         chk("rst_err0", re0, 0); chk("rst_err1", re1, 0);
         chk("rst_pay0", rp0, 0); chk("rst_pay1", rp1, 0);
      end
      if (rv0) rlog.push_back('{1'b0, re0, rp0, cyc});
      if (rv1) rlog.push_back('{1'b1, re1, rp1, cyc});
      if (rv0 && rv1) n_both++;
      if (pen_o) plog.push_back(cyc);
      obs_r0 = r0; obs_r1 = r1; obs_rv0 = rv0; obs_rv1 = rv1; obs_pen = pen_o;
      obs_ptag = p_tag_o;
      @(posedge clk);
      post_rst = rst;
      if (rst) begin
         mq0.delete(); mq1.delete(); m_last = 1; m_pv = 0;
      end else if (flush) begin
         mq0.delete(); mq1.delete(); m_pv = 0;
      end else begin
         m_pv = g;
         if (g) begin
            m_pid = gid; m_perr = herr; m_preq = h;
            m_ppay = herr ? '0 : extract(h.line, int'(h.off));
            if (gid) void'(mq1.pop_front()); else void'(mq0.pop_front());
            m_last = gid;
         end
         if (v0 && rd0) begin r = '{line0, tag0, idx0, off0}; mq0.push_back(r); end
         if (v1 && rd1) begin r = '{line1, tag1, idx1, off1}; mq1.push_back(r); end
      end
      @(negedge clk);
   endtask

   task automatic rand_req(input bit n);
      logic [LW-1:0] l;
      int o;
      for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
      o = ($urandom_range(0, 3) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 31);
      if (n) begin
         line1 = l; tag1 = TW'({$urandom, $urandom}); idx1 = IW'($urandom); off1 = OW'(o);
      end else begin
         line0 = l; tag0 = TW'({$urandom, $urandom}); idx0 = IW'($urandom); off0 = OW'(o);
      end
   endtask

   initial begin
      int acc, sent0, sent1, lows;
      for (int i = 0; i < LW / 8; i++) lineb[i*8 +: 8] = 8'(i);
      vt[0] = '{1'b0, 4,  1'b0, 32'h04050607};
      vt[1] = '{1'b1, 0,  1'b0, 32'h00010203};
      vt[2] = '{1'b0, 27, 1'b0, 32'h1B1C1D1E};
      vt[3] = '{1'b1, 28, 1'b0, 32'h1C1D1E1F};
      vt[4] = '{1'b1, 29, 1'b1, 32'h00000000};
      vt[5] = '{1'b0, 31, 1'b1, 32'h00000000};
      rst = 1; flush = 0; v0 = 0; v1 = 0;
      line0 = lineb; line1 = lineb; tag0 = '0; tag1 = '0;
      idx0 = '0; idx1 = '0; off0 = '0; off1 = '0;

      // Reset state
      step(); step();
      chk("rst_ready0", obs_r0, 0); chk("rst_ready1", obs_r1, 0); chk("rst_pen", obs_pen, 0);
      rst = 0;
      step();
      chk("post_rst_ready0", obs_r0, 1); chk("post_rst_resp0", obs_rv0, 0);

      // Contention: 6 requests each, grants must alternate starting with fetch
      rlog.delete(); n_both = 0; sent0 = 0; sent1 = 0;
      for (int c = 0; c < 60 && rlog.size() < 12; c++) begin
         v0 = (sent0 < 6); v1 = (sent1 < 6);
         tag0 = TW'(sent0 + 16'h100); tag1 = TW'(sent1 + 16'h200);
         step();
         if (v0 && obs_r0) sent0++;
         if (v1 && obs_r1) sent1++;
      end
      v0 = 0; v1 = 0;
      chk("alt_count", rlog.size(), 12);
      for (int i = 0; i < rlog.size(); i++) chk("alt_id", rlog[i].id, i % 2);
      chk("alt_simul", n_both, 0);
      step(); step();

      // Table of single requests across the offset boundary
      foreach (vt[i]) begin
         rlog.delete(); plog.delete();
         if (vt[i].id) begin v1 = 1; line1 = lineb; off1 = OW'(vt[i].off); tag1 = TW'(i + 100); end
         else          begin v0 = 1; line0 = lineb; off0 = OW'(vt[i].off); tag0 = TW'(i + 100); end
         step();
         acc = cyc;
         v0 = 0; v1 = 0;
         for (int w = 0; w < 6 && rlog.size() == 0; w++) step();
         chk("vec_seen", rlog.size(), 1);
         if (rlog.size() > 0) begin
            chk("vec_id", rlog[0].id, vt[i].id);
            chk("vec_err", rlog[0].err, vt[i].err);
            chk("vec_pay", rlog[0].pay, vt[i].pay);
            chk("vec_lat", rlog[0].cyc - acc, 2);
         end
         chk("vec_pen_cnt", plog.size(), vt[i].err ? 0 : 1);
         if (!vt[i].err && plog.size() > 0) chk("vec_pen_lat", plog[0] - acc, 1);
         step();
      end

      // Fetch queue fills while load is being granted; then flush right after a grant
      lows = 0; line0 = lineb; line1 = lineb; off0 = 5'd1; off1 = 5'd2;
      for (int c = 0; c < 8; c++) begin
         v0 = 1; v1 = 1;
         step();
         if (!obs_r0) lows++;
      end
      chk("full_fetch_lows", lows, 3);
      v0 = 0; v1 = 0; flush = 1;
      step();
      chk("flush_resp0", obs_rv0, 0); chk("flush_resp1", obs_rv1, 0); chk("flush_pen", obs_pen, 0);
      flush = 0;
      step();
      chk("flush_ready0", obs_r0, 1); chk("flush_ready1", obs_r1, 1);
      chk("flush_after_resp0", obs_rv0, 0); chk("flush_after_resp1", obs_rv1, 0);

      // Reset mid-stream
      v0 = 1; v1 = 1;
      step(); step(); step();
      rst = 1;
      step();
      chk("mid_rst_pen", obs_pen, 0); chk("mid_rst_rv0", obs_rv0, 0); chk("mid_rst_rv1", obs_rv1, 0);
      rst = 0; v0 = 0; v1 = 0;
      step();
      chk("mid_rst_after_rdy0", obs_r0, 1); chk("mid_rst_after_rdy1", obs_r1, 1);
      chk("mid_rst_after_rv0", obs_rv0, 0); chk("mid_rst_after_rv1", obs_rv1, 0);
      rlog.delete();
      tag0 = TW'(16'hF0F0); tag1 = TW'(16'h0F0F); v0 = 1; v1 = 1;
      step();
      v0 = 0; v1 = 0;
      step();
      chk("mid_rst_first_tag", obs_ptag, TW'(16'hF0F0));
      for (int w = 0; w < 6 && rlog.size() < 2; w++) step();
      chk("mid_rst_resp_cnt", rlog.size(), 2);
      if (rlog.size() > 0) chk("mid_rst_first_id", rlog[0].id, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         flush = !rst && ($urandom_range(0, 39) == 0);
         v0    = ($urandom_range(0, 2) != 0);
         v1    = ($urandom_range(0, 2) != 0);
         rand_req(1'b0);
         rand_req(1'b1);
         step();
      end
      rst = 0; flush = 0; v0 = 0; v1 = 0;
      for (int c = 0; c < 6; c++) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
